mult_share_arbiter: RTL and testbench



---
 rtl/mult_share_arbiter.sv | 148 ++++++++++++++
 tb/tb_mult_share_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - shares one signed 16x16 carry-save multiplier among NREQ requesters
// Optional feature macro: MULT_SHARE_ARBITER_FIXED_PRIO_EN (fixed-priority grant instead of round-robin)
module mult_share_arbiter #(
   parameter int NREQ     = 4,
   parameter int PIPE_LAT = 0,
   parameter int IDW      = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*16-1:0] req_a,
   input  logic [NREQ*16-1:0] req_b,
   output logic [15:0]       mul_a,
   output logic [15:0]       mul_b,
   output logic              mul_ce,
   input  logic [31:0]       mul_out0,
   input  logic [31:0]       mul_out1,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [31:0]       rsp_prod
);

   // S0 plus one tag-only stage per datapath register stage
   localparam int NST = PIPE_LAT + 1;

   logic [NST-1:0] vld_q, vld_d;
   logic [IDW-1:0] tag_q [NST];
   logic [IDW-1:0] tag_d [NST];
   logic [15:0]    a_q, a_d, b_q, b_d;
   logic           rsp_v_q, rsp_v_d;
   logic [IDW-1:0] rsp_id_q, rsp_id_d;
   logic [31:0]    rsp_prod_q, rsp_prod_d;
`ifndef MULT_SHARE_ARBITER_FIXED_PRIO_EN
   logic [IDW-1:0] ptr_q, ptr_d;
`endif

   logic           adv;
   logic           found;
   logic           hs;
   logic [IDW-1:0] grant;
   logic [15:0]    sel_a, sel_b;

   // the whole pipeline moves only when the response slot is free or being drained
   assign adv       = !rsp_v_q | rsp_ready;
   assign hs        = found & adv;
   assign mul_ce    = adv;
   assign mul_a     = a_q;
   assign mul_b     = b_q;
   assign rsp_valid = rsp_v_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_prod  = rsp_prod_q;

   // pick the winning requester; descending loops leave the lowest qualifying index
   always_comb begin
      found = 1'b0;
      grant = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            found = 1'b1;
            grant = IDW'(i);
         end
      end
`ifndef MULT_SHARE_ARBITER_FIXED_PRIO_EN
      // prefer requesters at or above the pointer; the pass above covers the wrap case
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i] && (IDW'(i) >= ptr_q)) begin
            grant = IDW'(i);
         end
      end
`endif
   end

   // one-hot accept and operand mux for the granted requester
   always_comb begin
      req_ready = '0;
      sel_a     = '0;
      sel_b     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant == IDW'(i)) begin
            req_ready[i] = hs;
            sel_a        = req_a[16*i +: 16];
            sel_b        = req_b[16*i +: 16];
         end
      end
   end

   // next state: shift tags with the datapath and fold the carry-save rows into the product
   always_comb begin
      vld_d      = vld_q;
      tag_d      = tag_q;
      a_d        = a_q;
      b_d        = b_q;
      rsp_v_d    = rsp_v_q;
      rsp_id_d   = rsp_id_q;
      rsp_prod_d = rsp_prod_q;
`ifndef MULT_SHARE_ARBITER_FIXED_PRIO_EN
      ptr_d      = ptr_q;
`endif
      if (adv) begin
         vld_d[0] = hs;
         if (hs) begin
            a_d      = sel_a;
            b_d      = sel_b;
            tag_d[0] = grant;
`ifndef MULT_SHARE_ARBITER_FIXED_PRIO_EN
            ptr_d    = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
`endif
         end
         for (int j = 1; j < NST; j++) begin
            vld_d[j] = vld_q[j-1];
            tag_d[j] = tag_q[j-1];
         end
         rsp_v_d    = vld_q[NST-1];
         rsp_id_d   = tag_q[NST-1];
         rsp_prod_d = mul_out0 + mul_out1;
      end
   end

   // state registers; reset drops every in-flight operation
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q      <= '0;
         for (int j = 0; j < NST; j++) tag_q[j] <= '0;
         a_q        <= '0;
         b_q        <= '0;
         rsp_v_q    <= 1'b0;
         rsp_id_q   <= '0;
         rsp_prod_q <= '0;
`ifndef MULT_SHARE_ARBITER_FIXED_PRIO_EN
         ptr_q      <= '0;
`endif
      end else begin
         vld_q      <= vld_d;
         tag_q      <= tag_d;
         a_q        <= a_d;
         b_q        <= b_d;
         rsp_v_q    <= rsp_v_d;
         rsp_id_q   <= rsp_id_d;
         rsp_prod_q <= rsp_prod_d;
`ifndef MULT_SHARE_ARBITER_FIXED_PRIO_EN
         ptr_q      <= ptr_d;
`endif
      end
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - randomized self-checking bench for mult_share_arbiter
module tb_mult_share_arbiter;

   localparam int NREQ     = 4;
   localparam int PIPE_LAT = 2;
   localparam int IDW      = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*16-1:0] req_a;
   logic [NREQ*16-1:0] req_b;
   logic [15:0]       mul_a, mul_b;
   logic              mul_ce;
   logic [31:0]       mul_out0, mul_out1;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [31:0]       rsp_prod;

   mult_share_arbiter #(.NREQ(NREQ), .PIPE_LAT(PIPE_LAT), .IDW(IDW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .mul_a(mul_a), .mul_b(mul_b), .mul_ce(mul_ce),
      .mul_out0(mul_out0), .mul_out1(mul_out1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_prod(rsp_prod)
   );

   always #5 clk = ~clk;

   // model datapath: two register stages, product split into two random carry-save rows
   logic [31:0] dp_s1 = '0;
   logic [31:0] dp_s2 = '0;
   logic [31:0] split_r = '0;
   always @(posedge clk) begin
      if (mul_ce) begin
         dp_s1 <= 32'($signed(mul_a)) * 32'($signed(mul_b));
         dp_s2 <= dp_s1;
      end
      split_r <= $urandom;
   end
   assign mul_out0 = split_r;
   assign mul_out1 = dp_s2 - split_r;

   // reference model: ordered queue of accepted jobs, each released PIPE_LAT+1 advances later
   typedef struct {
      int          cnt;
      int          id;
      logic [31:0] prod;
   } ent_t;
   ent_t        infl[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          p_m = 0;
   int          adv_cnt = 0;
   int          m_g;
   bit          exp_adv;
   bit          m_rsp_v = 0;
   int          m_rsp_id = 0;
   logic [31:0] m_rsp_prod = '0;
   logic [NREQ-1:0] exp_ready;

   function automatic int model_grant(logic [NREQ-1:0] v, int p);
`ifdef MULT_SHARE_ARBITER_FIXED_PRIO_EN
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
      for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
      return -1;
   endfunction

   function automatic logic [31:0] op_prod(int g);
      int a, b;
      a = int'($signed(req_a[16*g +: 16]));
      b = int'($signed(req_b[16*g +: 16]));
      return 32'(a * b);
   endfunction

   task automatic eval_model();
      exp_adv   = !m_rsp_v || rsp_ready;
      m_g       = model_grant(req_valid, p_m);
      exp_ready = (m_g >= 0 && exp_adv) ? (NREQ'(1) << m_g) : '0;
   endtask

   task automatic commit_model();
      ent_t e;
      if (rst) begin
         p_m = 0; adv_cnt = 0; m_rsp_v = 0; m_rsp_id = 0; m_rsp_prod = '0;
         infl.delete();
      end else if (exp_adv) begin
         adv_cnt++;
         m_rsp_v = 0;
         if (infl.size() > 0 && infl[0].cnt == adv_cnt - (PIPE_LAT + 1)) begin
            e = infl.pop_front();
            m_rsp_v = 1; m_rsp_id = e.id; m_rsp_prod = e.prod;
         end
         if (m_g >= 0) begin
            e.cnt = adv_cnt; e.id = m_g; e.prod = op_prod(m_g);
            infl.push_back(e);
            p_m = (m_g + 1) % NREQ;
         end
      end
   endtask

   // advance with the model kept in sync, no checking
   task automatic idle_cycles(int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk); eval_model(); commit_model();
         @(posedge clk); #1;
      end
   endtask

   task automatic rand_ops();
      for (int i = 0; i < NREQ; i++) begin
         req_a[16*i +: 16] = 16'($urandom);
         req_b[16*i +: 16] = 16'($urandom);
      end
   endtask

   task automatic test_reset();
      rst = 1; req_valid = '1; rsp_ready = 1; rand_ops();
      idle_cycles(2);
      rst = 0; req_valid = '0;
      @(negedge clk); eval_model();
      n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
      n_chk++; if (rsp_id !== '0) begin n_fail++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
      n_chk++; if (rsp_prod !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_prod got %h exp 0", rsp_prod); end
      n_chk++; if ({mul_a, mul_b} !== 32'h0) begin n_fail++; $display("FAIL reset_operands got %h/%h exp 0/0", mul_a, mul_b); end
      n_chk++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
      n_chk++; if (mul_ce !== 1'b1) begin n_fail++; $display("FAIL reset_mul_ce got %b exp 1", mul_ce); end
      commit_model();
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      int seen;
      seen = -1;
      req_valid = 4'b0100;
      req_a[32 +: 16] = 16'h0007; req_b[32 +: 16] = 16'hFFFD;
      @(negedge clk); eval_model();
      n_chk++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got %b exp 0100", req_ready); end
      commit_model();
      @(posedge clk); #1;
      req_valid = '0;
      for (int c = 1; c <= PIPE_LAT + 3; c++) begin
         @(negedge clk); eval_model();
         if (rsp_valid === 1'b1 && seen < 0) seen = c;
         if (c == PIPE_LAT + 2) begin
            n_chk++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_prod !== 32'hFFFFFFEB) begin
               n_fail++; $display("FAIL single_rsp got v=%b id=%0d prod=%h exp v=1 id=2 prod=ffffffeb", rsp_valid, rsp_id, rsp_prod);
            end
         end
         n_chk++; if (rsp_valid !== m_rsp_v) begin n_fail++; $display("FAIL single_valid c=%0d got %b exp %b", c, rsp_valid, m_rsp_v); end
         commit_model();
         @(posedge clk); #1;
      end
      n_chk++; if (seen !== PIPE_LAT + 2) begin n_fail++; $display("FAIL single_latency got %0d exp %0d", seen, PIPE_LAT + 2); end
   endtask

   task automatic test_round_robin();
      req_valid = '1; rsp_ready = 1;
      for (int c = 0; c < 16 + PIPE_LAT + 2; c++) begin
         rand_ops();
         if (c == 0) begin
            req_a[0 +: 16]  = 16'h8000; req_b[0 +: 16]  = 16'h8000;
            req_a[16 +: 16] = 16'h7FFF; req_b[16 +: 16] = 16'h8000;
         end
         if (c >= 16) req_valid = '0;
         @(negedge clk); eval_model();
         n_chk++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rr_ready c=%0d got %b exp %b", c, req_ready, exp_ready); end
         n_chk++; if (rsp_valid !== m_rsp_v) begin n_fail++; $display("FAIL rr_valid c=%0d got %b exp %b", c, rsp_valid, m_rsp_v); end
         if (m_rsp_v) begin
            n_chk++;
            if (rsp_id !== IDW'(m_rsp_id) || rsp_prod !== m_rsp_prod) begin
               n_fail++; $display("FAIL rr_rsp c=%0d got id=%0d prod=%h exp id=%0d prod=%h", c, rsp_id, rsp_prod, m_rsp_id, m_rsp_prod);
            end
         end
         commit_model();
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stall();
      bit          hold;
      logic [IDW-1:0] s_id;
      logic [31:0] s_prod;
      hold = 0; s_id = '0; s_prod = '0;
      req_valid = '1;
      for (int c = 0; c < 14 + PIPE_LAT + 2; c++) begin
         rand_ops();
         rsp_ready = !(c >= 4 && c < 7);
         if (c >= 14) req_valid = '0;
         @(negedge clk); eval_model();
         n_chk++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL stall_ready c=%0d got %b exp %b", c, req_ready, exp_ready); end
         n_chk++; if (mul_ce !== exp_adv) begin n_fail++; $display("FAIL stall_ce c=%0d got %b exp %b", c, mul_ce, exp_adv); end
         n_chk++; if (rsp_valid !== m_rsp_v) begin n_fail++; $display("FAIL stall_valid c=%0d got %b exp %b", c, rsp_valid, m_rsp_v); end
         if (m_rsp_v) begin
            n_chk++;
            if (rsp_id !== IDW'(m_rsp_id) || rsp_prod !== m_rsp_prod) begin
               n_fail++; $display("FAIL stall_rsp c=%0d got id=%0d prod=%h exp id=%0d prod=%h", c, rsp_id, rsp_prod, m_rsp_id, m_rsp_prod);
            end
         end
         if (hold) begin
            n_chk++;
            if (rsp_valid !== 1'b1 || rsp_id !== s_id || rsp_prod !== s_prod) begin
               n_fail++; $display("FAIL stall_hold c=%0d got v=%b id=%0d prod=%h exp v=1 id=%0d prod=%h", c, rsp_valid, rsp_id, rsp_prod, s_id, s_prod);
            end
         end
         hold = rsp_valid && !rsp_ready; s_id = rsp_id; s_prod = rsp_prod;
         commit_model();
         @(posedge clk); #1;
      end
      rsp_ready = 1;
   endtask

   task automatic test_random();
      int n_acc, n_seen, c;
      n_acc = 0; n_seen = 0; c = 0;
      while ((n_acc < 20 || infl.size() > 0 || m_rsp_v) && c < 500) begin
         rand_ops();
         req_valid = (n_acc < 20) ? NREQ'($urandom) : '0;
         rsp_ready = ($urandom % 4) != 0;
         @(negedge clk); eval_model();
         n_chk++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready c=%0d got %b exp %b", c, req_ready, exp_ready); end
         n_chk++; if (rsp_valid !== m_rsp_v) begin n_fail++; $display("FAIL rand_valid c=%0d got %b exp %b", c, rsp_valid, m_rsp_v); end
         if (m_rsp_v) begin
            n_chk++;
            if (rsp_id !== IDW'(m_rsp_id) || rsp_prod !== m_rsp_prod) begin
               n_fail++; $display("FAIL rand_rsp c=%0d got id=%0d prod=%h exp id=%0d prod=%h", c, rsp_id, rsp_prod, m_rsp_id, m_rsp_prod);
            end
         end
         if (exp_adv && m_g >= 0) n_acc++;
         if (rsp_valid === 1'b1 && rsp_ready) n_seen++;
         commit_model();
         @(posedge clk); #1;
         c++;
      end
      rsp_ready = 1;
      n_chk++; if (n_seen !== n_acc || c >= 500) begin n_fail++; $display("FAIL rand_count got %0d responses exp %0d (cycles %0d)", n_seen, n_acc, c); end
   endtask

   task automatic test_reset_inflight();
      req_valid = '1; rsp_ready = 1; rand_ops();
      idle_cycles(2);
      rst = 1;
      idle_cycles(1);
      rst = 0; req_valid = '0;
      for (int c = 0; c < PIPE_LAT + 3; c++) begin
         @(negedge clk); eval_model();
         n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstfl_valid c=%0d got %b exp 0", c, rsp_valid); end
         commit_model();
         @(posedge clk); #1;
      end
      req_valid = '1;
      @(negedge clk); eval_model();
      n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rstfl_grant got %b exp 0001", req_ready); end
      commit_model();
      @(posedge clk); #1;
      req_valid = '0;
      idle_cycles(PIPE_LAT + 3);
   endtask

   task automatic test_arb_pair();
      logic [NREQ-1:0] prev;
      prev = '0;
      req_valid = 4'b1010; rsp_ready = 1;
      for (int c = 0; c < 8; c++) begin
         rand_ops();
         if (c >= 6) req_valid = 4'b1000;
         @(negedge clk); eval_model();
         n_chk++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL pair_ready c=%0d got %b exp %b", c, req_ready, exp_ready); end
`ifdef MULT_SHARE_ARBITER_FIXED_PRIO_EN
         n_chk++;
         if (req_ready !== ((c >= 6) ? 4'b1000 : 4'b0010)) begin n_fail++; $display("FAIL pair_fixed c=%0d got %b", c, req_ready); end
`else
         if (c > 0 && c < 6) begin
            n_chk++; if (req_ready === prev) begin n_fail++; $display("FAIL pair_alternate c=%0d got %b exp not %b", c, req_ready, prev); end
         end
`endif
         prev = req_ready;
         commit_model();
         @(posedge clk); #1;
      end
      req_valid = '0;
      idle_cycles(PIPE_LAT + 3);
   endtask

   initial begin
      rst = 1; req_valid = '0; rsp_ready = 1; req_a = '0; req_b = '0;
      @(posedge clk); #1;
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_random();
      test_reset_inflight();
      test_arb_pair();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
